// File: rtl/uart_rx_if.sv
// Serial line and received-byte bundle between a UART transmitter/line driver and uart_rx.
`timescale 1ns/1ps
interface uart_rx_if;
  logic       parity_type;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output parity_type, rx,
    input  rx_data, rx_valid, parity_err, frame_err
  );

  modport slave (
    input  parity_type, rx,
    output rx_data, rx_valid, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one even/odd parity bit, one stop bit,
// mid-bit sampling on a free-running baud counter, with parity and framing error flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 27,
  parameter int SAMPLE_PT    = 13
) (
  input  logic     clk_3125,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   baud_cnt, baud_cnt_d;
  logic [IDX_W-1:0]   bit_idx, bit_idx_d;
  logic [DATA_W-1:0]  shreg, shreg_d;
  logic               par_bit, par_bit_d;
  logic               frame_done;
  logic               rx_sync_p0, rx_sync_p1;
  logic               rx_s;

  function automatic logic parity_mismatch(input logic [DATA_W-1:0] d,
                                           input logic odd, input logic p);
    return (^d ^ odd) != p;
  endfunction

  // Stage p0/p1: two-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_s = rx_sync_p1;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
    end
  end

  always_ff @(posedge clk_3125) begin
    shreg   <= shreg_d;
    par_bit <= par_bit_d;
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + CNT_W'(1);
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    par_bit_d  = par_bit;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (baud_cnt == CNT_SAMPLE && rx_s) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else if (baud_cnt == CNT_LAST) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end
      DATA: begin
        if (baud_cnt == CNT_SAMPLE) shreg_d = {rx_s, shreg[DATA_W-1:1]};
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx == IDX_LAST) state_d = PARITY;
          else bit_idx_d = bit_idx + IDX_W'(1);
        end
      end
      PARITY: begin
        if (baud_cnt == CNT_SAMPLE) par_bit_d = rx_s;
        if (baud_cnt == CNT_LAST) begin
          state_d    = STOP;
          baud_cnt_d = '0;
        end
      end
      STOP: begin
        // Leave at the stop sample so a start edge right after the stop bit is caught
        if (baud_cnt == CNT_SAMPLE) begin
          frame_done = 1'b1;
          baud_cnt_d = '0;
          state_d    = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        baud_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_valid   <= 1'b0;
      bus.rx_data    <= '0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.rx_valid <= frame_done;
      if (frame_done) begin
        bus.rx_data    <= shreg;
        bus.parity_err <= parity_mismatch(shreg, bus.parity_type, par_bit);
        bus.frame_err  <= ~rx_s;
      end
    end
  end

endmodule
